// File: rtl/parking_gate_ctrl_if.sv
// Signal bundle between the gate controller, the sensors/barriers and the
// downstream next-free-slot decoder.
interface parking_gate_ctrl_if;
    logic       enter_req;
    logic       exit_req;
    logic [3:0] exit_slot;
    logic [3:0] next_parking;
    logic [3:0] state;
    logic [3:0] assigned_slot;
    logic       assign_valid;
    logic       entry_gate_open;
    logic       exit_gate_open;
    logic       full;
    logic [2:0] occupied_count;
    logic       full_reject;
    logic       exit_error;

    modport master (
        output enter_req, exit_req, exit_slot, next_parking,
        input  state, assigned_slot, assign_valid, entry_gate_open, exit_gate_open,
        input  full, occupied_count, full_reject, exit_error
    );

    modport slave (
        input  enter_req, exit_req, exit_slot, next_parking,
        output state, assigned_slot, assign_valid, entry_gate_open, exit_gate_open,
        output full, occupied_count, full_reject, exit_error
    );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Occupancy owner and entry/exit barrier sequencer for a 4-slot lot.
// Exit requests win over entry; HOLD states stop a car idling at a sensor being served twice.
module parking_gate_ctrl #(
    parameter int unsigned GATE_OPEN_CYCLES = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    parking_gate_ctrl_if.slave   io_bus
);

    localparam int unsigned CntW = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(GATE_OPEN_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StEnterOpen,
        StEnterHold,
        StExitOpen,
        StExitHold
    } fsm_e;

    fsm_e            r_fsm, w_fsm_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [3:0]      r_state, w_state_d;
    logic [3:0]      r_slot, w_slot_d;
    logic            r_assign_valid, w_assign_valid_d;
    logic            r_full_reject, w_full_reject_d;
    logic            r_exit_error, w_exit_error_d;
    logic            r_full;
    logic [2:0]      r_count;

    logic [3:0] w_exit_m1, w_np_m1;
    logic [3:0] w_exit_mask, w_np_mask;
    logic       w_exit_ok;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    assign w_exit_m1   = io_bus.exit_slot - 4'd1;
    assign w_np_m1     = io_bus.next_parking - 4'd1;
    assign w_exit_mask = 4'b0001 << w_exit_m1[1:0];
    // A decoder value above 4 is malformed; refuse to set any occupancy bit for it.
    assign w_np_mask   = (io_bus.next_parking <= 4'd4) ? (4'b0001 << w_np_m1[1:0]) : 4'b0000;
    assign w_exit_ok   = (io_bus.exit_slot != 4'd0) && (io_bus.exit_slot <= 4'd4) &&
                         ((r_state & w_exit_mask) != 4'b0000);

    always_comb begin
        w_fsm_d          = r_fsm;
        w_cnt_d          = r_cnt;
        w_state_d        = r_state;
        w_slot_d         = r_slot;
        w_assign_valid_d = 1'b0;
        w_full_reject_d  = 1'b0;
        w_exit_error_d   = 1'b0;
        case (r_fsm)
            StIdle: begin
                w_cnt_d = '0;
                if (io_bus.exit_req) begin
                    if (w_exit_ok) begin
                        w_state_d = r_state & ~w_exit_mask;
                        w_fsm_d   = StExitOpen;
                    end else begin
                        w_exit_error_d = 1'b1;
                        w_fsm_d        = StExitHold;
                    end
                end else if (io_bus.enter_req) begin
                    if (io_bus.next_parking != 4'd0) begin
                        w_state_d        = r_state | w_np_mask;
                        w_slot_d         = io_bus.next_parking;
                        w_assign_valid_d = 1'b1;
                        w_fsm_d          = StEnterOpen;
                    end else begin
                        w_full_reject_d = 1'b1;
                        w_fsm_d         = StEnterHold;
                    end
                end
            end
            StEnterOpen, StExitOpen: begin
                if (r_cnt == CntLast) begin
                    w_cnt_d = '0;
                    w_fsm_d = (r_fsm == StEnterOpen) ? StEnterHold : StExitHold;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StEnterHold: if (!io_bus.enter_req) w_fsm_d = StIdle;
            StExitHold:  if (!io_bus.exit_req)  w_fsm_d = StIdle;
            default:     w_fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm          <= StIdle;
            r_cnt          <= '0;
            r_state        <= 4'b0000;
            r_slot         <= 4'd0;
            r_assign_valid <= 1'b0;
            r_full_reject  <= 1'b0;
            r_exit_error   <= 1'b0;
            r_full         <= 1'b0;
            r_count        <= 3'd0;
        end else begin
            r_fsm          <= w_fsm_d;
            r_cnt          <= w_cnt_d;
            r_state        <= w_state_d;
            r_slot         <= w_slot_d;
            r_assign_valid <= w_assign_valid_d;
            r_full_reject  <= w_full_reject_d;
            r_exit_error   <= w_exit_error_d;
            r_full         <= (w_state_d == 4'b1111);
            r_count        <= popcount4(w_state_d);
        end
    end

    assign io_bus.state           = r_state;
    assign io_bus.assigned_slot   = r_slot;
    assign io_bus.assign_valid    = r_assign_valid;
    assign io_bus.entry_gate_open = (r_fsm == StEnterOpen);
    assign io_bus.exit_gate_open  = (r_fsm == StExitOpen);
    assign io_bus.full            = r_full;
    assign io_bus.occupied_count  = r_count;
    assign io_bus.full_reject     = r_full_reject;
    assign io_bus.exit_error      = r_exit_error;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with a behavioural next-free-slot decoder.
module tb_parking_gate_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errs;

    parking_gate_ctrl_if bus ();

    parking_gate_ctrl #(
        .GATE_OPEN_CYCLES(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational decoder: lowest clear bit of state, 0 when full.
    always_comb begin
        bus.next_parking = 4'd0;
        if      (!bus.state[0]) bus.next_parking = 4'd1;
        else if (!bus.state[1]) bus.next_parking = 4'd2;
        else if (!bus.state[2]) bus.next_parking = 4'd3;
        else if (!bus.state[3]) bus.next_parking = 4'd4;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count consecutive cycles the selected gate is high, starting now.
    task automatic gate_len(input bit entry, output int n);
        n = 0;
        while ((entry ? bus.entry_gate_open : bus.exit_gate_open) && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic do_entry(input logic [3:0] slot, input logic [3:0] st);
        int n;
        bus.enter_req = 1'b1;
        tick();
        chk("entry_slot", {4'd0, bus.assigned_slot}, {4'd0, slot});
        chk("entry_state", {4'd0, bus.state}, {4'd0, st});
        chk("entry_valid", {7'd0, bus.assign_valid}, 8'd1);
        gate_len(1'b1, n);
        chk("entry_gate_len", n[7:0], 8'd8);
        bus.enter_req = 1'b0;
        tick();
        chk("entry_valid_low", {7'd0, bus.assign_valid}, 8'd0);
    endtask

    task automatic do_exit(input logic [3:0] slot, input logic [3:0] st);
        int n;
        bus.exit_req  = 1'b1;
        bus.exit_slot = slot;
        tick();
        chk("exit_state", {4'd0, bus.state}, {4'd0, st});
        gate_len(1'b0, n);
        chk("exit_gate_len", n[7:0], 8'd8);
        bus.exit_req = 1'b0;
        tick();
    endtask

    task automatic do_bad_exit(input logic [3:0] slot, input logic [3:0] st);
        bus.exit_req  = 1'b1;
        bus.exit_slot = slot;
        tick();
        chk("bad_exit_err", {7'd0, bus.exit_error}, 8'd1);
        chk("bad_exit_state", {4'd0, bus.state}, {4'd0, st});
        chk("bad_exit_gate", {7'd0, bus.exit_gate_open}, 8'd0);
        tick();
        chk("bad_exit_err_once", {7'd0, bus.exit_error}, 8'd0);
        bus.exit_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int n;
        n_checks      = 0;
        n_errs        = 0;
        rst_n         = 1'b0;
        bus.enter_req = 1'b0;
        bus.exit_req  = 1'b0;
        bus.exit_slot = 4'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_state", {4'd0, bus.state}, 8'd0);
        chk("rst_slot", {4'd0, bus.assigned_slot}, 8'd0);
        chk("rst_count", {5'd0, bus.occupied_count}, 8'd0);
        chk("rst_misc", {3'd0, bus.full, bus.entry_gate_open, bus.exit_gate_open,
                         bus.full_reject, bus.exit_error}, 8'd0);

        // Fill the lot
        do_entry(4'd1, 4'b0001);
        do_entry(4'd2, 4'b0011);
        do_entry(4'd3, 4'b0111);
        do_entry(4'd4, 4'b1111);
        chk("fill_count", {5'd0, bus.occupied_count}, 8'd4);
        chk("fill_full", {7'd0, bus.full}, 8'd1);

        // Entry refused when full, single pulse while held
        bus.enter_req = 1'b1;
        tick();
        chk("rej_pulse", {7'd0, bus.full_reject}, 8'd1);
        chk("rej_state", {4'd0, bus.state}, 8'h0f);
        chk("rej_gate", {7'd0, bus.entry_gate_open}, 8'd0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n += int'(bus.full_reject) + int'(bus.entry_gate_open);
        end
        chk("rej_held_quiet", n[7:0], 8'd0);
        bus.enter_req = 1'b0;
        tick();
        bus.enter_req = 1'b1;
        tick();
        chk("rej_retry_pulse", {7'd0, bus.full_reject}, 8'd1);
        bus.enter_req = 1'b0;
        tick();

        // Exit slot 2, then the next entry refills it
        do_exit(4'd2, 4'b1101);
        chk("exit_count", {5'd0, bus.occupied_count}, 8'd3);
        chk("exit_full", {7'd0, bus.full}, 8'd0);
        do_entry(4'd2, 4'b1111);

        // Get to 0011, then simultaneous requests
        do_exit(4'd4, 4'b0111);
        do_exit(4'd3, 4'b0011);
        bus.enter_req = 1'b1;
        bus.exit_req  = 1'b1;
        bus.exit_slot = 4'd1;
        tick();
        chk("both_state", {4'd0, bus.state}, 8'h02);
        chk("both_entry_gate", {7'd0, bus.entry_gate_open}, 8'd0);
        gate_len(1'b0, n);
        chk("both_exit_len", n[7:0], 8'd8);
        tick();
        tick();
        chk("both_hold_state", {4'd0, bus.state}, 8'h02);
        chk("both_hold_gate", {7'd0, bus.entry_gate_open}, 8'd0);
        bus.exit_req = 1'b0;
        tick();
        tick();
        chk("both_entry_slot", {4'd0, bus.assigned_slot}, 8'd1);
        chk("both_entry_state", {4'd0, bus.state}, 8'h03);
        chk("both_entry_valid", {7'd0, bus.assign_valid}, 8'd1);
        gate_len(1'b1, n);
        chk("both_entry_len", n[7:0], 8'd8);
        bus.enter_req = 1'b0;
        tick();

        // Invalid exits
        do_bad_exit(4'd0, 4'b0011);
        do_bad_exit(4'd5, 4'b0011);
        do_bad_exit(4'd3, 4'b0011);

        // Reset in the 4th cycle of an entry gate
        bus.enter_req = 1'b1;
        tick();
        chk("pre_rst_state", {4'd0, bus.state}, 8'h07);
        tick();
        tick();
        tick();
        chk("pre_rst_gate", {7'd0, bus.entry_gate_open}, 8'd1);
        bus.enter_req = 1'b0;
        rst_n         = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_state", {4'd0, bus.state}, 8'd0);
        chk("mid_rst_gate", {7'd0, bus.entry_gate_open}, 8'd0);
        chk("mid_rst_slot", {4'd0, bus.assigned_slot}, 8'd0);
        do_entry(4'd1, 4'b0001);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Sequential owner of the 4-bit parking occupancy vector for a 4-slot lot. Bit i set means slot i+1 is occupied.
- Drives `state` into the downstream combinational next-free-slot decoder and consumes its `next_parking` result. `next_parking` is 1..4 for the lowest free slot, or 0 when the lot is full.
- Sequences the entry and exit gates, handles arrival/departure requests, and flags rejects and errors.

Parameters:
- GATE_OPEN_CYCLES, default 8: number of cycles a gate-open output stays high per accepted event; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- enter_req  in  1  car present at entry sensor (level)
- exit_req  in  1  car present at exit sensor (level)
- exit_slot  in  4  slot number (1..4) of the departing car, sampled with exit_req
- next_parking  in  4  lowest free slot from the downstream decoder (0 = full)
- state  out  4  registered occupancy vector, bit i = slot i+1 occupied
- assigned_slot  out  4  slot granted to the most recent accepted entry
- assign_valid  out  1  one-cycle pulse when assigned_slot is updated
- entry_gate_open  out  1  entry barrier open
- exit_gate_open  out  1  exit barrier open
- full  out  1  registered, high when state == 4'b1111
- occupied_count  out  3  registered popcount of state (0..4)
- full_reject  out  1  one-cycle pulse: entry refused because lot is full
- exit_error  out  1  one-cycle pulse: exit_slot out of range or slot not occupied

Behaviour:
Reset (rst_n low at a rising edge):
- All outputs go to 0: state=0, assigned_slot=0, count=0, full=0, all pulses and gates 0.
- FSM goes to IDLE and the gate counter clears.
- Reset mid-gate-cycle aborts immediately and discards occupancy.

FSM states: IDLE, ENTER_OPEN, ENTER_HOLD, EXIT_OPEN, EXIT_HOLD.

IDLE:
- Requests are evaluated every cycle. exit_req takes priority over enter_req when both are high.
- Exit accepted (exit_req, exit_slot in 1..4, state[exit_slot-1]=1):
  - state bit is cleared at the next edge;
  - go to EXIT_OPEN;
  - exit_gate_open is high from the next cycle.
- Exit invalid (exit_slot==0, exit_slot>4, or bit already clear):
  - exit_error pulses for 1 cycle;
  - state is unchanged;
  - go to EXIT_HOLD, with no gate open.
- Entry with next_parking != 0:
  - at the next edge, assigned_slot <= next_parking, state[next_parking-1] <= 1, assign_valid pulses;
  - go to ENTER_OPEN;
  - entry_gate_open is high from the next cycle.
- Entry with next_parking == 0:
  - full_reject pulses for 1 cycle;
  - go to ENTER_HOLD, with no gate open.
- next_parking is used the same cycle it is presented, because the decoder is combinational from the registered state.
- Only one bit of state changes per accepted event.

ENTER_OPEN / EXIT_OPEN:
- The gate output is high for exactly GATE_OPEN_CYCLES cycles.
- The counter counts 0..GATE_OPEN_CYCLES-1; at terminal count, go to the matching HOLD state.
- All requests are ignored during OPEN states.

ENTER_HOLD / EXIT_HOLD:
- Wait until the corresponding request is low, then return to IDLE.
- This prevents one parked-at-sensor car from being granted twice.
- The other request is ignored until IDLE.

Derived outputs:
- full and occupied_count are registered from the next value of state, so they change in the same cycle as state.
- Outputs not being pulsed hold their value; assigned_slot holds until the next accepted entry.
- Width rules:
  - exit_slot is compared as unsigned 4-bit;
  - popcount result fits in 3 bits;
  - the gate counter is $clog2(GATE_OPEN_CYCLES) bits wide.

Test Plan:
1. Reset, then four enter_req pulses, each dropped after the gate closes. Required: assigned_slot sequence 1,2,3,4; state 0001, 0011, 0111, 1111; occupied_count 4; full=1; each entry_gate_open lasts exactly 8 cycles.
2. Lot full, enter_req raised. Required: full_reject pulses once; state stays 1111; no gate opens; no second pulse while enter_req is held; a new attempt is accepted only after enter_req drops.
3. From 1111, exit_req with exit_slot=2, then enter_req. Required: state goes 1101 with exit_gate_open for 8 cycles; the entry then gets assigned_slot=2 and state returns to 1111.
4. From 0011, enter_req and exit_req (exit_slot=1) raised in the same cycle. Required: exit is served first and state goes 0010. After EXIT_HOLD releases and exit_req drops, the still-high enter_req is accepted with assigned_slot=1 and state becomes 0011.
5. exit_slot=0, then 5, then 3 with state=0011. Required: exit_error pulses each time; state unchanged; exit_gate_open stays 0.
6. rst_n driven low for one cycle at the 4th cycle of an entry gate opening. Required: next cycle state=0, entry_gate_open=0, FSM in IDLE; a following entry gets slot 1.
